song_sequencer: RTL and testbench

//  Parametrised song playback and scoring engine for the note game; replaces the fixed half-second song_select stub.

---
 rtl/game_pkg.sv | 31 +++
 rtl/song_sequencer_interval_pulse.sv | 32 +++
 rtl/song_sequencer.sv | 154 +++++++++++++++
 tb/tb_song_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared note-game definitions: note encoding, sequencer states and display/game modes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

  localparam int NOTE_BITS = 7;

  // Note code 0 is silence; 7'h7F in the song ROM terminates a song early.
  localparam logic [NOTE_BITS-1:0] REST_NOTE = 7'h00;
  localparam logic [NOTE_BITS-1:0] END_NOTE  = 7'h7F;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

  // Top-level game modes, shared with game_controller and the VGA front end.
  typedef enum logic [1:0] {
    GAME_MENU   = 2'd0,
    GAME_PLAY   = 2'd1,
    GAME_RESULT = 2'd2
  } game_state_t;

  localparam logic [1:0] VGA_MODE_MENU  = 2'd0;
  localparam logic [1:0] VGA_MODE_NOTES = 2'd1;
  localparam logic [1:0] VGA_MODE_SCORE = 2'd2;

endpackage

// File: rtl/song_sequencer_interval_pulse.sv
// Free-running modulo-PERIOD counter with synchronous clear and enable; tick marks the wrap cycle.
// Latency: tick is combinational from the count, asserted in the cycle the count sits at PERIOD-1.
// Backpressure: en_i low freezes the count and suppresses the tick.
module interval_pulse #(
  parameter int PERIOD = 5,
  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  logic [W-1:0] count_q;
  logic         at_top;

  assign at_top = (count_q == W'(PERIOD - 1));
  assign tick_o = en_i && at_top;

  // Count enabled cycles, wrapping to zero after PERIOD-1; clear has priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= at_top ? '0 : count_q + W'(1);
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Song playback and scoring: fetches notes from a 1-cycle song ROM, holds each NOTE_CYCLES, scores player samples.
// Latency: start -> first note on 'note' with playing=1 three cycles later; 2 fetch cycles between notes.
// Backpressure: pause (level) freezes counters/score in PLAY; abort returns to IDLE from any state.
module song_sequencer
  import game_pkg::*;
#(
  parameter int NUM_SONGS        = 4,
  parameter int MAX_NOTES        = 256,
  parameter int NOTE_BITS        = game_pkg::NOTE_BITS,
  parameter int NOTE_CYCLES      = 50_000_000,
  parameter int SAMPLES_PER_NOTE = 5,
  parameter int SCORE_BITS       = 10,
  parameter int SONG_BITS        = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  localparam int IDX_BITS        = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start,
  input  logic [SONG_BITS-1:0]          song_id,
  input  logic                          pause,
  input  logic                          abort,
  input  logic [NOTE_BITS-1:0]          player_note,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [NOTE_BITS-1:0]          rom_data,
  output logic [NOTE_BITS-1:0]          note,
  output logic [IDX_BITS-1:0]           note_idx,
  output logic                          playing,
  output logic                          done,
  output logic                          hit,
  output logic [SCORE_BITS-1:0]         score
);

  localparam int SAMPLE_INTERVAL = NOTE_CYCLES / SAMPLES_PER_NOTE;
  // Samples are only taken inside the first SAMPLES_PER_NOTE whole intervals of a note.
  localparam int SAMPLE_SPAN     = SAMPLE_INTERVAL * SAMPLES_PER_NOTE;
  localparam int CNT_W           = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;

  localparam logic [SONG_BITS:0]     SONG_LIMIT = (SONG_BITS + 1)'(NUM_SONGS);
  localparam logic [SONG_BITS-1:0]   SONG_LAST  = SONG_BITS'(NUM_SONGS - 1);
  localparam logic [IDX_BITS-1:0]    IDX_LAST   = IDX_BITS'(MAX_NOTES - 1);
  localparam logic [CNT_W-1:0]       CYC_LAST   = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [SCORE_BITS-1:0]  SCORE_MAX  = '1;
  localparam logic [NOTE_BITS-1:0]   NOTE_REST  = NOTE_BITS'(REST_NOTE);
  localparam logic [NOTE_BITS-1:0]   NOTE_END   = NOTE_BITS'(END_NOTE);

  seq_state_t                  state_q;
  logic [SONG_BITS-1:0]        song_q;
  logic [IDX_BITS-1:0]         idx_q;
  logic [SONG_BITS+IDX_BITS-1:0] rom_addr_q;
  logic [NOTE_BITS-1:0]        note_q;
  logic [CNT_W-1:0]            cyc_q;
  logic [SCORE_BITS-1:0]       score_q, score_d;
  logic                        playing_q, done_q;

  logic [SONG_BITS-1:0]        song_sel;
  logic [IDX_BITS-1:0]         idx_next;
  logic                        play_active, sample_en, sample_tick, note_match;

  assign song_sel    = ({1'b0, song_id} >= SONG_LIMIT) ? SONG_LAST : song_id;
  assign idx_next    = idx_q + IDX_BITS'(1);
  assign play_active = (state_q == S_PLAY) && !pause;
  assign sample_en   = play_active && ({1'b0, cyc_q} < (CNT_W + 1)'(SAMPLE_SPAN));
  assign note_match  = (player_note == note_q) && (note_q != NOTE_REST);
  assign hit         = sample_tick && note_match;
  assign score_d     = (hit && (score_q != SCORE_MAX)) ? score_q + SCORE_BITS'(1) : score_q;

  // Sample tick restarts with every freshly loaded note.
  interval_pulse #(
    .PERIOD (SAMPLE_INTERVAL)
  ) u_sample_tick (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .clr_i  (state_q == S_LOAD),
    .en_i   (sample_en),
    .tick_o (sample_tick)
  );

  // Sequencer FSM: song fetch, note hold, scoring and end-of-song detection.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      song_q     <= '0;
      idx_q      <= '0;
      rom_addr_q <= '0;
      note_q     <= NOTE_REST;
      cyc_q      <= '0;
      score_q    <= '0;
      playing_q  <= 1'b0;
      done_q     <= 1'b0;
    end else if (abort) begin
      // Score is deliberately kept so the display can still show it.
      state_q   <= S_IDLE;
      note_q    <= NOTE_REST;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            song_q     <= song_sel;
            idx_q      <= '0;
            score_q    <= '0;
            rom_addr_q <= {song_sel, {IDX_BITS{1'b0}}};
            done_q     <= 1'b0;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          if (rom_data == NOTE_END) begin
            note_q  <= NOTE_REST;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            note_q    <= rom_data;
            cyc_q     <= '0;
            playing_q <= 1'b1;
            state_q   <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (!pause) begin
            score_q <= score_d;
            if (cyc_q == CYC_LAST) begin
              playing_q <= 1'b0;
              if (idx_q == IDX_LAST) begin
                note_q  <= NOTE_REST;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                idx_q      <= idx_next;
                rom_addr_q <= {song_q, idx_next};
                state_q    <= S_FETCH;
              end
            end else begin
              cyc_q <= cyc_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr = rom_addr_q;
  assign note     = note_q;
  assign note_idx = idx_q;
  assign playing  = playing_q;
  assign done     = done_q;
  assign score    = score_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: expected note starts and hit cycles are queued at start and popped as the DUT plays.
// Latency: cycle numbers are relative to the cycle in which start is driven (cycle 0).
// Backpressure: pause and abort are driven on schedules inside each scenario.
module tb_song_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, pause, abort;

  logic       a_start, a_track, a_playing, a_done, a_hit;
  logic [1:0] a_song;
  logic [6:0] a_player, a_rom_data, a_note;
  logic [4:0] a_rom_addr;
  logic [2:0] a_idx;
  logic [9:0] a_score;

  logic       b_start, b_playing, b_done, b_hit;
  logic [2:0] b_song, b_idx, b_score;
  logic [6:0] b_player, b_rom_data, b_note;
  logic [5:0] b_rom_addr;

  logic [6:0] rom_a [32];
  logic [6:0] rom_b [64];

  song_sequencer #(.NUM_SONGS(4), .MAX_NOTES(8), .NOTE_CYCLES(10), .SAMPLES_PER_NOTE(2), .SCORE_BITS(10)) dut_a (
    .clk_in(clk), .rst_in(rst_n), .start(a_start), .song_id(a_song), .pause(pause), .abort(abort),
    .player_note(a_player), .rom_addr(a_rom_addr), .rom_data(a_rom_data), .note(a_note),
    .note_idx(a_idx), .playing(a_playing), .done(a_done), .hit(a_hit), .score(a_score)
  );

  song_sequencer #(.NUM_SONGS(4), .MAX_NOTES(8), .NOTE_CYCLES(10), .SAMPLES_PER_NOTE(2), .SCORE_BITS(3),
                   .SONG_BITS(3)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .start(b_start), .song_id(b_song), .pause(pause), .abort(abort),
    .player_note(b_player), .rom_addr(b_rom_addr), .rom_data(b_rom_data), .note(b_note),
    .note_idx(b_idx), .playing(b_playing), .done(b_done), .hit(b_hit), .score(b_score)
  );

  // Song ROMs with one cycle of read latency.
  always @(posedge clk) begin
    a_rom_data <= rom_a[a_rom_addr];
    b_rom_data <= rom_b[b_rom_addr];
  end

  // A perfect player simply echoes the target note.
  assign a_player = a_track ? a_note : 7'd0;
  assign b_player = b_note;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [6:0] note;
  } ev_t;

  ev_t note_q[$];
  int  hit_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic push_note(input int c, input logic [6:0] n);
    ev_t e;
    e.cyc  = c;
    e.note = n;
    note_q.push_back(e);
  endtask

  task automatic start_a(input logic [1:0] s, output int c0);
    @(posedge clk); #1;
    a_song  = s;
    a_start = 1'b1;
    c0      = cyc;
  endtask

  // Runs DUT A for ncyc cycles, driving pause/abort schedules and checking against the queues.
  task automatic watch_a(input int c0, input int ncyc, input int pause_at, input int pause_len,
                         input int abort_at, input int exp_done, input int exp_addr1);
    bit         prev_play = 1'b0;
    logic [6:0] prev_note = 7'd0;
    int         rel, done_at, h;
    ev_t        e;
    done_at = -1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      rel     = cyc - c0;
      pause   = (rel >= pause_at) && (rel < pause_at + pause_len);
      abort   = (rel == abort_at);
      a_start = (rel == abort_at);
      @(negedge clk);
      if (rel == 1) begin
        n_checks++;
        if (int'(a_rom_addr) != exp_addr1) begin
          n_fail++;
          $display("FAIL rom_addr_first: got %0d expected %0d", a_rom_addr, exp_addr1);
        end
      end
      if (a_playing && (!prev_play || a_note !== prev_note)) begin
        n_checks++;
        if (note_q.size() == 0) begin
          n_fail++;
          $display("FAIL note_start: got note %0d at cycle %0d expected none", a_note, rel);
        end else begin
          e = note_q.pop_front();
          if (e.cyc != rel || e.note !== a_note) begin
            n_fail++;
            $display("FAIL note_start: got note %0d at cycle %0d expected note %0d at cycle %0d",
                     a_note, rel, e.note, e.cyc);
          end
        end
      end
      if (a_hit) begin
        n_checks++;
        if (hit_q.size() == 0) begin
          n_fail++;
          $display("FAIL hit_pulse: got hit at cycle %0d expected none", rel);
        end else begin
          h = hit_q.pop_front();
          if (h != rel) begin
            n_fail++;
            $display("FAIL hit_pulse: got hit at cycle %0d expected cycle %0d", rel, h);
          end
        end
      end
      if (a_done && done_at < 0) done_at = rel;
      prev_play = a_playing;
      prev_note = a_note;
    end
    pause   = 1'b0;
    abort   = 1'b0;
    a_start = 1'b0;
    n_checks++;
    if (note_q.size() != 0 || hit_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d notes %0d hits outstanding expected 0 0", note_q.size(), hit_q.size());
    end
    note_q.delete();
    hit_q.delete();
    if (exp_done >= 0) begin
      n_checks++;
      if (done_at != exp_done) begin
        n_fail++;
        $display("FAIL done_cycle: got %0d expected %0d", done_at, exp_done);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pause = 1'b0; abort = 1'b0;
    a_start = 1'b0; a_song = '0; a_track = 1'b0;
    b_start = 1'b0; b_song = '0;
    #2;
    n_checks++;
    if ({a_note, a_idx, a_rom_addr, a_playing, a_done, a_hit, a_score} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got note=%0d idx=%0d addr=%0d play=%b done=%b hit=%b score=%0d expected all 0",
               a_note, a_idx, a_rom_addr, a_playing, a_done, a_hit, a_score);
    end
    n_checks++;
    if ({b_note, b_idx, b_rom_addr, b_playing, b_done, b_hit, b_score} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got note=%0d score=%0d play=%b expected all 0", b_note, b_score, b_playing);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (a_playing !== 1'b0 || a_rom_addr !== 5'd0 || a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got play=%b addr=%0d done=%b expected 0 0 0", a_playing, a_rom_addr, a_done);
    end
  endtask

  // Silent player: two notes, sentinel, no hits.
  task automatic test_play_song();
    int c0;
    a_track = 1'b0;
    push_note(3, 7'd60);
    push_note(15, 7'd62);
    start_a(2'd1, c0);
    watch_a(c0, 30, -1, 0, -1, 27, 8);
    n_checks++;
    if (a_score !== 10'd0) begin
      n_fail++;
      $display("FAIL score_silent: got %0d expected 0", a_score);
    end
  endtask

  task automatic test_scoring();
    int c0;
    a_track = 1'b1;
    push_note(3, 7'd60);
    push_note(15, 7'd62);
    hit_q.push_back(7); hit_q.push_back(12); hit_q.push_back(19); hit_q.push_back(24);
    start_a(2'd1, c0);
    watch_a(c0, 30, -1, 0, -1, 27, 8);
    n_checks++;
    if (a_score !== 10'd4) begin
      n_fail++;
      $display("FAIL score_match: got %0d expected 4", a_score);
    end
  endtask

  task automatic test_pause();
    int c0;
    a_track = 1'b1;
    push_note(3, 7'd60);
    push_note(20, 7'd62);
    hit_q.push_back(12); hit_q.push_back(17); hit_q.push_back(24); hit_q.push_back(29);
    start_a(2'd1, c0);
    watch_a(c0, 35, 6, 5, -1, 32, 8);
    n_checks++;
    if (a_score !== 10'd4) begin
      n_fail++;
      $display("FAIL score_pause: got %0d expected 4", a_score);
    end
  endtask

  task automatic test_abort();
    int c0;
    a_track = 1'b1;
    push_note(3, 7'd60);
    hit_q.push_back(7);
    start_a(2'd1, c0);
    watch_a(c0, 14, -1, 0, 9, -1, 8);
    n_checks++;
    if (a_playing !== 1'b0 || a_note !== 7'd0 || a_done !== 1'b0 || a_score !== 10'd1) begin
      n_fail++;
      $display("FAIL abort_idle: got play=%b note=%0d done=%b score=%0d expected 0 0 0 1",
               a_playing, a_note, a_done, a_score);
    end
  endtask

  // Full-length 8-note song on the 3-bit score build; song_id 5 must clamp to song 3.
  task automatic test_saturate();
    int  c0, rel, h, done_at;
    bit  prev_play = 1'b0;
    ev_t e;
    done_at = -1;
    for (int k = 0; k < 8; k++) begin
      push_note(3 + 12 * k, 7'(10 + k));
      hit_q.push_back(7 + 12 * k);
      hit_q.push_back(12 + 12 * k);
    end
    @(posedge clk); #1;
    b_song  = 3'd5;
    b_start = 1'b1;
    c0      = cyc;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      b_start = 1'b0;
      rel     = cyc - c0;
      @(negedge clk);
      if (rel == 1) begin
        n_checks++;
        if (b_rom_addr !== 6'd24) begin
          n_fail++;
          $display("FAIL clamp_addr: got %0d expected 24", b_rom_addr);
        end
      end
      if (b_playing && !prev_play) begin
        n_checks++;
        if (note_q.size() == 0) begin
          n_fail++;
          $display("FAIL sat_note: got note %0d at cycle %0d expected none", b_note, rel);
        end else begin
          e = note_q.pop_front();
          if (e.cyc != rel || e.note !== b_note) begin
            n_fail++;
            $display("FAIL sat_note: got note %0d at cycle %0d expected note %0d at cycle %0d",
                     b_note, rel, e.note, e.cyc);
          end
        end
      end
      if (b_hit) begin
        n_checks++;
        h = (hit_q.size() == 0) ? -1 : hit_q.pop_front();
        if (h != rel) begin
          n_fail++;
          $display("FAIL sat_hit: got hit at cycle %0d expected cycle %0d", rel, h);
        end
      end
      if (rel == 87) begin
        n_checks++;
        if (b_idx !== 3'd7) begin
          n_fail++;
          $display("FAIL last_idx: got %0d expected 7", b_idx);
        end
      end
      if (b_done && done_at < 0) done_at = rel;
      prev_play = b_playing;
    end
    n_checks++;
    if (note_q.size() != 0 || hit_q.size() != 0 || done_at != 97) begin
      n_fail++;
      $display("FAIL sat_end: got %0d notes %0d hits left done at %0d expected 0 0 97",
               note_q.size(), hit_q.size(), done_at);
    end
    note_q.delete();
    hit_q.delete();
    n_checks++;
    if (b_score !== 3'd7 || b_idx !== 3'd7) begin
      n_fail++;
      $display("FAIL sat_score: got score=%0d idx=%0d expected 7 7", b_score, b_idx);
    end
  endtask

  task automatic test_async_reset();
    int c0;
    a_track = 1'b1;
    start_a(2'd1, c0);
    repeat (5) begin
      @(posedge clk); #1;
      a_start = 1'b0;
    end
    n_checks++;
    if (a_playing !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_play: got %b expected 1", a_playing);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_note, a_idx, a_rom_addr, a_playing, a_done, a_hit, a_score} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got note=%0d idx=%0d addr=%0d play=%b done=%b hit=%b score=%0d expected all 0",
               a_note, a_idx, a_rom_addr, a_playing, a_done, a_hit, a_score);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    push_note(3, 7'd60);
    push_note(15, 7'd62);
    hit_q.push_back(7); hit_q.push_back(12); hit_q.push_back(19); hit_q.push_back(24);
    start_a(2'd1, c0);
    watch_a(c0, 30, -1, 0, -1, 27, 8);
    n_checks++;
    if (a_score !== 10'd4) begin
      n_fail++;
      $display("FAIL score_after_reset: got %0d expected 4", a_score);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom_a[i] = 7'h7F;
    for (int i = 0; i < 64; i++) rom_b[i] = 7'h7F;
    rom_a[8] = 7'd60;
    rom_a[9] = 7'd62;
    for (int i = 0; i < 8; i++) rom_b[24 + i] = 7'(10 + i);
    test_reset();
    test_play_song();
    test_scoring();
    test_pause();
    test_abort();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
